// File: rtl/result_writer.sv
// rtl/result_writer.sv - packs 8-bit result pixels four per word and writes them to image memory.
// Optional binarisation of incoming pixels: define RESULT_WRITER_THRESH_EN.
module result_writer #(
    parameter int         WORDS_PER_IMAGE = 25344,
    parameter int         BASE_ADDR       = 25344,
    parameter logic [7:0] THRESHOLD       = 8'd128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        mem_gnt,
    output logic [15:0] addr,
    output logic [31:0] dataW,
    output logic        en,
    output logic        we,
    output logic        finish
);

    localparam logic [16:0] PIX_TOTAL = 17'(4 * WORDS_PER_IMAGE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [16:0] pix_cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic [31:0] fifo_mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  fifo_cnt, fifo_cnt_nxt;
    logic        accept, push, pop, last_pix;
    logic [7:0]  pix_b;

`ifdef RESULT_WRITER_THRESH_EN
    assign pix_b = (pix_in >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    logic [7:0] unused_threshold;
    assign unused_threshold = THRESHOLD;
    assign pix_b = pix_in;
`endif

    // Ready looks at the pre-pop count, so a full FIFO costs one stall cycle.
    assign pix_ready = (state == RUN) && (fifo_cnt < 2'd2);
    assign accept    = pix_valid && pix_ready;
    assign push      = accept && (byte_cnt == 2'd3);
    assign last_pix  = accept && (pix_cnt == PIX_TOTAL - 17'd1);
    assign en        = (fifo_cnt != 2'd0) && mem_gnt;
    assign we        = en;
    assign pop       = en;
    assign addr      = 16'(BASE_ADDR) + word_idx;
    assign dataW     = fifo_mem[rd_ptr];
    assign finish    = (state == DONE);

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop)
            fifo_cnt_nxt = fifo_cnt + 2'd1;
        else if (pop && !push)
            fifo_cnt_nxt = fifo_cnt - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_pix) state_nxt = DRAIN;
            // Leaving on the committing edge lets finish follow the last write directly.
            DRAIN:   if (fifo_cnt_nxt == 2'd0) state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            partial     <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                pix_cnt  <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
            end else begin
                if (accept) begin
                    if (pix_cnt != PIX_TOTAL)
                        pix_cnt <= pix_cnt + 17'd1;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt != 2'd3)
                        partial[8*byte_cnt +: 8] <= pix_b;
                end
                if (pop)
                    word_idx <= word_idx + 16'd1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= {pix_b, partial};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - randomized self-checking bench for result_writer against a pixel/word queue model.
module tb_result_writer;

    localparam int WPI  = 4;
    localparam int BASE = 16;
    localparam int NPIX = 4 * WPI;

    logic        clk = 1'b0;
    logic        reset, start, pix_valid, mem_gnt;
    logic [7:0]  pix_in;
    logic        pix_ready, en, we, finish;
    logic [15:0] addr;
    logic [31:0] dataW;

    int n_checks = 0;
    int n_fail   = 0;

    result_writer #(.WORDS_PER_IMAGE(WPI), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .mem_gnt(mem_gnt),
        .addr(addr), .dataW(dataW), .en(en), .we(we), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pix(input logic [7:0] p);
`ifdef RESULT_WRITER_THRESH_EN
        return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  pix_ready, 0);
        check({tag, "_en"},     en, 0);
        check({tag, "_we"},     we, 0);
        check({tag, "_addr"},   addr, BASE);
        check({tag, "_data"},   dataW, 0);
        check({tag, "_finish"}, finish, 0);
    endtask

    // mode 0: full grant, pixels 1..16; 1: grant held low 12 cycles; 2: random; 3: threshold pattern.
    // abort_at >= 0 asserts reset once that many pixels are accepted.
    task automatic run_frame(input int mode, input int abort_at);
        logic [31:0] words[$];
        logic [7:0]  grp [4];
        logic [7:0]  tpat [4];
        int acc, wr, cyc, pend;
        bit exp_ready, exp_en;
        tpat[0] = 8'h7F; tpat[1] = 8'h80; tpat[2] = 8'h00; tpat[3] = 8'hFF;
        acc = 0; wr = 0; cyc = 0;
        start = 1'b1; pix_valid = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        check("ready_before_start_edge", pix_ready, 0);
        @(posedge clk); #1;
        while (wr < WPI && cyc < 2000) begin
            cyc++;
            if (abort_at >= 0 && acc == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_ready", pix_ready, 0);
                check("abort_en", en, 0);
                check("abort_finish", finish, 0);
                pix_valid = 1'b0; start = 1'b0; mem_gnt = 1'b0;
                return;
            end
            case (mode)
                0, 3: begin pix_valid = 1'b1; mem_gnt = 1'b1; end
                1:    begin pix_valid = 1'b1; mem_gnt = (cyc > 12); end
                default: begin
                    pix_valid = ($urandom_range(0, 3) != 0);
                    mem_gnt   = ($urandom_range(0, 2) == 0);
                    start     = $urandom_range(0, 1) != 0;
                end
            endcase
            if (mode == 0)      pix_in = 8'(acc + 1);
            else if (mode == 3) pix_in = tpat[acc % 4];
            else                pix_in = 8'($urandom);
            @(negedge clk);
            pend      = acc / 4 - wr;
            exp_ready = (acc < NPIX) && (pend < 2);
            exp_en    = (pend > 0) && mem_gnt;
            check("pix_ready", pix_ready, exp_ready);
            check("en", en, exp_en);
            check("we", we, exp_en);
            check("finish_early", finish, 0);
            if (exp_en) begin
                check("wr_addr", addr, BASE + wr);
                check("wr_data", dataW, words[wr]);
                wr++;
            end
            if (pix_valid && exp_ready) begin
                grp[acc % 4] = model_pix(pix_in);
                acc++;
                if (acc % 4 == 0)
                    words.push_back({grp[3], grp[2], grp[1], grp[0]});
            end
            @(posedge clk); #1;
        end
        check("frame_in_budget", (cyc < 2000), 1);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_valid = $urandom_range(0, 1) != 0;
            mem_gnt   = 1'b1;
            @(negedge clk);
            check("done_finish", finish, 1);
            check("done_ready", pix_ready, 0);
            check("done_en", en, 0);
            @(posedge clk); #1;
        end
        start = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        check("finish_hold", finish, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("finish_clear", finish, 0);
        check("idle_en", en, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; mem_gnt = 1'b0; pix_in = 8'h00;
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1; mem_gnt = 1'b1; pix_in = 8'($urandom);
            @(negedge clk);
            check("idle_ready", pix_ready, 0);
            check("idle_en", en, 0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(0, 6);
        @(posedge clk); #1;
        check_idle_outputs("reset_mid");
        reset = 1'b0;
        @(posedge clk); #1;
        run_frame(0, -1);
        for (int f = 0; f < 6; f++)
            run_frame(2, -1);
        run_frame(3, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
